// File: rtl/flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_sample_sequencer
//  Description : Flash word-address walker and Avalon-MM read sequencer.
//                Fetches one 32-bit word per step from flash, moving forward
//                or backward through the address space. Each word is split
//                into two 16-bit audio samples, one emitted per sample_tick.
//                read_finish pulses once both halves of a word have been
//                emitted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                       in   1           system clock (posedge)
//    reset                     in   1           synchronous active-high reset
//    i_start_read              in   1           run enable (level)
//    i_dir                     in   1           0 = forward, 1 = backward
//    i_restart                 in   1           jump to start/end at word end
//    i_sample_tick             in   1           audio-rate strobe (sync'd)
//    o_flash_mem_read          out  1           Avalon read request
//    o_flash_mem_address       out  ADDR_WIDTH  Avalon word address
//    o_flash_mem_byteenable    out  4           always 4'b1111
//    i_flash_mem_waitrequest   in   1           slave stall
//    i_flash_mem_readdata      in   32          read data
//    i_flash_mem_readdatavalid in   1           read data qualifier
//    o_audio_sample            out  16          current sample (held)
//    o_sample_valid            out  1           pulse on sample update
//    o_read_finish             out  1           pulse once per finished word
// ============================================================================
module flash_sample_sequencer #(
  parameter int                    ADDR_WIDTH    = 23,
  parameter logic [ADDR_WIDTH-1:0] MAX_WORD_ADDR = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start_read,
  input  logic                  i_dir,
  input  logic                  i_restart,
  input  logic                  i_sample_tick,
  output logic                  o_flash_mem_read,
  output logic [ADDR_WIDTH-1:0] o_flash_mem_address,
  output logic [3:0]            o_flash_mem_byteenable,
  input  logic                  i_flash_mem_waitrequest,
  input  logic [31:0]           i_flash_mem_readdata,
  input  logic                  i_flash_mem_readdatavalid,
  output logic [15:0]           o_audio_sample,
  output logic                  o_sample_valid,
  output logic                  o_read_finish
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_T1   = 3'd3,
    S_WAIT_T2   = 3'd4,
    S_ADVANCE   = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_word_addr;
  logic                  r_order;      // 1: upper half is played first
  logic [31:0]           r_word;
  logic                  r_read;
  logic [15:0]           r_sample;
  logic                  r_sample_valid;
  logic                  r_read_finish;

  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [15:0]           w_first_half;
  logic [15:0]           w_second_half;

  // Next word address, evaluated with the restart/dir levels present in the
  // ADVANCE cycle. Restart takes priority and jumps to the end matching dir.
  always_comb begin
    w_addr_next = r_word_addr;
    if (i_restart) begin
      w_addr_next = i_dir ? MAX_WORD_ADDR : '0;
    end else if (!i_dir) begin
      w_addr_next = (r_word_addr == MAX_WORD_ADDR) ? '0 : r_word_addr + 1'b1;
    end else begin
      w_addr_next = (r_word_addr == '0) ? MAX_WORD_ADDR : r_word_addr - 1'b1;
    end
  end

  // Playback order is fixed for the whole word by the dir value latched when
  // the request was issued, so a mid-word dir change cannot reorder halves.
  assign w_first_half  = r_order ? r_word[31:16] : r_word[15:0];
  assign w_second_half = r_order ? r_word[15:0]  : r_word[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_word_addr    <= '0;
      r_order        <= 1'b0;
      r_word         <= '0;
      r_read         <= 1'b0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_read_finish  <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_read_finish  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_read) begin
            r_state <= S_REQ;
            r_read  <= 1'b1;
            r_order <= i_dir;
          end
        end
        S_REQ: begin
          // Request and address stay put until the slave accepts.
          if (!i_flash_mem_waitrequest) begin
            r_state <= S_WAIT_DATA;
            r_read  <= 1'b0;
          end
        end
        S_WAIT_DATA: begin
          // Ticks arriving before data are intentionally not remembered.
          if (i_flash_mem_readdatavalid) begin
            r_word  <= i_flash_mem_readdata;
            r_state <= S_WAIT_T1;
          end
        end
        S_WAIT_T1: begin
          if (i_sample_tick) begin
            r_sample       <= w_first_half;
            r_sample_valid <= 1'b1;
            r_state        <= S_WAIT_T2;
          end
        end
        S_WAIT_T2: begin
          if (i_sample_tick) begin
            r_sample       <= w_second_half;
            r_sample_valid <= 1'b1;
            r_state        <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          // read_finish lands one cycle after the last sample_valid, so the
          // two pulses never overlap.
          r_read_finish <= 1'b1;
          r_word_addr   <= w_addr_next;
          if (i_start_read) begin
            r_state <= S_REQ;
            r_read  <= 1'b1;
            r_order <= i_dir;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  assign o_flash_mem_read       = r_read;
  assign o_flash_mem_address    = r_word_addr;
  assign o_flash_mem_byteenable = 4'b1111;
  assign o_audio_sample         = r_sample;
  assign o_sample_valid         = r_sample_valid;
  assign o_read_finish          = r_read_finish;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_sample_sequencer
//  Description : Scoreboard bench for flash_sample_sequencer. Directed words
//                push expected addresses and samples into queues; a monitor
//                pops and compares whenever the DUT accepts a read or
//                presents a sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_sample_sequencer;

  localparam logic [22:0] MAXA = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start_read;
  logic        i_dir;
  logic        i_restart;
  logic        i_sample_tick;
  logic        o_flash_mem_read;
  logic [22:0] o_flash_mem_address;
  logic [3:0]  o_flash_mem_byteenable;
  logic        i_flash_mem_waitrequest;
  logic [31:0] i_flash_mem_readdata;
  logic        i_flash_mem_readdatavalid;
  logic [15:0] o_audio_sample;
  logic        o_sample_valid;
  logic        o_read_finish;

  flash_sample_sequencer #(
    .ADDR_WIDTH   (23),
    .MAX_WORD_ADDR(MAXA)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .i_start_read             (i_start_read),
    .i_dir                    (i_dir),
    .i_restart                (i_restart),
    .i_sample_tick            (i_sample_tick),
    .o_flash_mem_read         (o_flash_mem_read),
    .o_flash_mem_address      (o_flash_mem_address),
    .o_flash_mem_byteenable   (o_flash_mem_byteenable),
    .i_flash_mem_waitrequest  (i_flash_mem_waitrequest),
    .i_flash_mem_readdata     (i_flash_mem_readdata),
    .i_flash_mem_readdatavalid(i_flash_mem_readdatavalid),
    .o_audio_sample           (o_audio_sample),
    .o_sample_valid           (o_sample_valid),
    .o_read_finish            (o_read_finish)
  );

  always #5 clk = ~clk;

  logic [15:0] q_samp[$];
  logic [22:0] q_addr[$];
  int n_cmp   = 0;
  int n_err   = 0;
  int n_words = 0;
  int n_acc   = 0;
  int n_fin   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic        m_prev_tick  = 1'b0;
  logic        m_prev_stall = 1'b0;
  logic        m_prev_rst   = 1'b1;
  logic [22:0] m_prev_addr  = '0;
  logic [15:0] m_exp_s;
  logic [22:0] m_exp_a;

  initial begin
    forever begin
      @(negedge clk);
      if (o_sample_valid) begin
        if (q_samp.size() == 0) begin
          fail("unexpected_sample");
        end else begin
          m_exp_s = q_samp.pop_front();
          chk("sample", {16'h0, o_audio_sample}, {16'h0, m_exp_s});
        end
        chk("tick_to_sample_latency", {31'h0, m_prev_tick}, 32'd1);
      end
      if (o_sample_valid && o_read_finish) fail("valid_and_finish_overlap");
      if (o_read_finish) n_fin++;
      if (m_prev_stall && !m_prev_rst) begin
        chk("stall_read_held", {31'h0, o_flash_mem_read}, 32'd1);
        chk("stall_addr_held", {9'h0, o_flash_mem_address}, {9'h0, m_prev_addr});
      end
      if (o_flash_mem_read && !i_flash_mem_waitrequest && !reset) begin
        n_acc++;
        if (q_addr.size() == 0) begin
          fail("unexpected_read_accept");
        end else begin
          m_exp_a = q_addr.pop_front();
          chk("read_address", {9'h0, o_flash_mem_address}, {9'h0, m_exp_a});
        end
      end
      m_prev_tick  = i_sample_tick;
      m_prev_stall = o_flash_mem_read && i_flash_mem_waitrequest;
      m_prev_rst   = reset;
      m_prev_addr  = o_flash_mem_address;
    end
  end

  // ------------------------------------------------------------ one word
  // a/d/ord: expected address, returned data, expected half order.
  // ws: waitrequest cycles, dvd: readdatavalid delay, haz: inject a dropped
  // tick and a stray readdatavalid, pause: drop start_read after sample 1,
  // nd/nr: dir/restart applied mid-word for the following step.
  task automatic do_word(input logic [22:0] a, input logic [31:0] d, input bit ord,
                         input int ws, input int dvd, input bit haz, input bit pause,
                         input bit nd, input bit nr);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (o_flash_mem_read) seen = 1'b1;
      else step();
    end
    if (!seen) begin
      fail("read_request_timeout");
      return;
    end
    n_words++;
    q_addr.push_back(a);
    q_samp.push_back(ord ? d[31:16] : d[15:0]);
    q_samp.push_back(ord ? d[15:0]  : d[31:16]);
    repeat (ws) step();
    i_flash_mem_waitrequest = 1'b0;
    step();
    i_flash_mem_waitrequest = 1'b1;
    if (haz) begin
      i_sample_tick = 1'b1;
      step();
      i_sample_tick = 1'b0;
    end
    repeat (dvd) step();
    i_flash_mem_readdatavalid = 1'b1;
    i_flash_mem_readdata      = d;
    step();
    i_flash_mem_readdatavalid = 1'b0;
    i_flash_mem_readdata      = '0;
    if (haz) begin
      step();
      i_flash_mem_readdatavalid = 1'b1;
      i_flash_mem_readdata      = 32'hDEAD_DEAD;
      step();
      i_flash_mem_readdatavalid = 1'b0;
      i_flash_mem_readdata      = '0;
    end
    step();
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    if (pause) i_start_read = 1'b0;
    i_dir     = nd;
    i_restart = nr;
    step();
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (o_read_finish) seen = 1'b1;
      else step();
    end
    if (!seen) fail("read_finish_timeout");
    i_restart = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  bit any_read;

  initial begin
    reset                     = 1'b1;
    i_start_read              = 1'b0;
    i_dir                     = 1'b0;
    i_restart                 = 1'b0;
    i_sample_tick             = 1'b0;
    i_flash_mem_waitrequest   = 1'b1;
    i_flash_mem_readdata      = '0;
    i_flash_mem_readdatavalid = 1'b0;
    repeat (3) step();
    chk("reset_read",       {31'h0, o_flash_mem_read}, 32'd0);
    chk("reset_addr",       {9'h0, o_flash_mem_address}, 32'd0);
    chk("reset_sample",     {16'h0, o_audio_sample}, 32'd0);
    chk("reset_valid",      {31'h0, o_sample_valid}, 32'd0);
    chk("reset_finish",     {31'h0, o_read_finish}, 32'd0);
    chk("byteenable",       {28'h0, o_flash_mem_byteenable}, 32'hF);
    reset = 1'b0;
    step();

    // Forward run
    i_start_read = 1'b1;
    do_word(23'd0, 32'hAAAA_5555, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_word(23'd1, 32'h1111_2222, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Stall, late data, dropped tick, stray readdatavalid
    do_word(23'd2, 32'hCAFE_BEEF, 1'b0, 5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    // Pause after first sample
    do_word(23'd3, 32'h0F0F_F0F0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    any_read = 1'b0;
    repeat (5) begin
      step();
      if (o_flash_mem_read) any_read = 1'b1;
    end
    chk("pause_idle_no_read", {31'h0, any_read}, 32'd0);
    chk("pause_addr_advanced", {9'h0, o_flash_mem_address}, 32'd4);
    i_start_read = 1'b1;

    // Walk forward up to 0x100
    for (int i = 4; i <= 255; i++) begin
      do_word(23'(i), {i[15:0] ^ 16'h5A5A, i[15:0]}, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Restart with dir = 0 at 0x100 -> 0
    do_word(23'h100, 32'h1357_2468, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_word(23'd0,   32'h2468_1357, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Turn backward at 1 -> 0, next word played upper half first
    do_word(23'd1,   32'h9ABC_DEF0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Backward wrap 0 -> MAX
    do_word(23'd0,   32'h1234_5678, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Forward wrap MAX -> 0
    do_word(MAXA,    32'h55AA_33CC, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Restart with dir = 1 -> MAX
    do_word(23'd0,   32'h0C0F_FEE0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_word(MAXA,    32'h7654_3210, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while in REQ
    chk("req_before_reset_read", {31'h0, o_flash_mem_read}, 32'd1);
    chk("req_before_reset_addr", {9'h0, o_flash_mem_address}, {9'h0, MAXA - 23'd1});
    step();
    step();
    reset        = 1'b1;
    i_start_read = 1'b0;
    step();
    reset = 1'b0;
    chk("midreset_read",   {31'h0, o_flash_mem_read}, 32'd0);
    chk("midreset_addr",   {9'h0, o_flash_mem_address}, 32'd0);
    chk("midreset_sample", {16'h0, o_audio_sample}, 32'd0);
    chk("midreset_valid",  {31'h0, o_sample_valid}, 32'd0);
    chk("midreset_finish", {31'h0, o_read_finish}, 32'd0);
    i_flash_mem_readdatavalid = 1'b1;
    i_flash_mem_readdata      = 32'h0BAD_0BAD;
    step();
    i_flash_mem_readdatavalid = 1'b0;
    i_flash_mem_readdata      = '0;
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    repeat (3) step();
    chk("post_reset_idle_read", {31'h0, o_flash_mem_read}, 32'd0);

    // Resume from address 0 after reset
    i_dir        = 1'b0;
    i_start_read = 1'b1;
    do_word(23'd0, 32'hFEDC_BA98, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_start_read = 1'b0;
    repeat (6) step();

    chk("samples_outstanding",   q_samp.size(), 32'd0);
    chk("addresses_outstanding", q_addr.size(), 32'd0);
    chk("reads_per_word",        n_acc, n_words);
    chk("finish_per_word",       n_fin, n_words);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
